// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// FSM encoding, register offsets and STATUS bit layout.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head entry always visible on rdata.
// Pointers wrap modulo DEPTH (power of 2); count spans 0..DEPTH.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// TXDATA at BASE+0, STATUS at BASE+4 (overflow is write-1-clear).
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 12000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_FFE0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write_mem,
   input  logic [31:0] write_address,
   input  logic [31:0] write_data,
   input  logic [31:0] read_address,
   output logic [31:0] read_data,
   output logic        tx,
   output logic        irq_empty
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + OFF_TXDATA;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + OFF_STATUS;

   tx_state_t     state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, idx_n;
   logic [7:0]    shreg, sh_n;
   logic          tx_n;
   logic          bit_end;
   logic          pop;
   logic          tx_busy;
   logic          overflow;

   logic          wr_txdata;
   logic          wr_status;
   logic          rd_status;
   logic [31:0]   status_w;

   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   logic          unused_bits;
   assign unused_bits = ^{write_data[31:8], write_address[1:0],
                          read_address[1:0]};

   assign wr_txdata = write_mem &&
                      (write_address[31:2] == TXDATA_ADDR[31:2]);
   assign wr_status = write_mem &&
                      (write_address[31:2] == STATUS_ADDR[31:2]);
   assign rd_status = (read_address[31:2] == STATUS_ADDR[31:2]);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_txdata),
      .wdata (write_data[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_busy   = (state != ST_IDLE);
   assign irq_empty = fifo_empty && !tx_busy;
   assign bit_end   = (baud_cnt == BAUD_LAST);

   always_comb begin
      status_w = '0;
      status_w[STAT_FULL]  = fifo_full;
      status_w[STAT_EMPTY] = fifo_empty;
      status_w[STAT_BUSY]  = tx_busy;
      status_w[STAT_OVF]   = overflow;
      status_w[STAT_CNT_LSB +: 8] = 8'(fifo_count);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
         overflow  <= 1'b0;
      end else begin
         read_data <= rd_status ? status_w : '0;
         // A dropped push outranks a same-cycle clear.
         if (wr_txdata && fifo_full)
            overflow <= 1'b1;
         else if (wr_status && write_data[STAT_OVF])
            overflow <= 1'b0;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      idx_n   = bit_idx;
      sh_n    = shreg;
      pop     = 1'b0;
      tx_n    = 1'b1;
      if (state != ST_IDLE)
         baud_n = bit_end ? '0 : baud_cnt + BW'(1);
      unique case (state)
         ST_IDLE: begin
            baud_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_n    = fifo_rdata;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) state_n = ST_IDLE;
         end
      endcase
      // Line level follows the next state so tx is glitch-free.
      case (state_n)
         ST_START: tx_n = 1'b0;
         ST_DATA:  tx_n = sh_n[idx_n];
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= idx_n;
         shreg    <= sh_n;
         tx       <= tx_n;
      end
   end

endmodule
